// File: rtl/keypad_entry.sv
// keypad_entry: 4x4 matrix keypad scanner with debounce and decimal entry.
// Scans one active-low column at a time, debounces complete 16-key snapshots,
// and accumulates typed digits into a 24-bit binary value committed by '#'.
// Optional feature: define KEYPAD_BACKSPACE_EN to make '*' delete the last
// digit; without it '*' is a plain key and no divider is built.
module keypad_entry #(
    parameter int SCAN_DIV     = 100_000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    output logic [23:0] entry,
    output logic [3:0]  digit_count,
    output logic [23:0] value,
    output logic        value_valid,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        overflow
);

    localparam int              DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]      DEB      = 4'(DEBOUNCE_CNT);

    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    typedef enum logic [1:0] {IDLE, PRESS, HELD} state_t;

    // Snapshot bit index is col*4 + row; map that position to its key code.
    function automatic logic [3:0] map_key(input logic [3:0] idx);
        logic [3:0] code;
        case (idx)
            4'd0:    code = 4'd1;
            4'd1:    code = 4'd4;
            4'd2:    code = 4'd7;
            4'd3:    code = KEY_STAR;
            4'd4:    code = 4'd2;
            4'd5:    code = 4'd5;
            4'd6:    code = 4'd8;
            4'd7:    code = 4'd0;
            4'd8:    code = 4'd3;
            4'd9:    code = 4'd6;
            4'd10:   code = 4'd9;
            4'd11:   code = KEY_HASH;
            4'd12:   code = 4'd10;
            4'd13:   code = 4'd11;
            4'd14:   code = 4'd12;
            default: code = KEY_D;
        endcase
        return code;
    endfunction

    logic [3:0]       row_meta_reg;
    logic [3:0]       row_sync_reg;
    logic [DIV_W-1:0] div_cnt_reg;
    logic [1:0]       col_reg;
    logic [11:0]      snap_acc_reg;

    state_t           state_reg;
    logic [3:0]       cand_reg;
    logic [3:0]       cnt_reg;
    logic [3:0]       rel_reg;

    logic [23:0]      entry_reg;
    logic [3:0]       digit_count_reg;
    logic [23:0]      value_reg;
    logic             value_valid_reg;
    logic             key_valid_reg;
    logic [3:0]       key_code_reg;
    logic             overflow_reg;

    logic             sample_now;
    logic             snap_done;
    logic [15:0]      snapshot;
    logic [4:0]       key_count;
    logic [3:0]       key_idx;
    logic             snap_none;
    logic             snap_single;
    logic [3:0]       snap_code;
    logic             accept;
    logic [27:0]      entry_x10;
    logic             digit_fits;

    assign col_out     = ~(4'b0001 << col_reg);
    assign entry       = entry_reg;
    assign digit_count = digit_count_reg;
    assign value       = value_reg;
    assign value_valid = value_valid_reg;
    assign key_valid   = key_valid_reg;
    assign key_code    = key_code_reg;
    assign overflow    = overflow_reg;

    // Two-flop synchronizer for the asynchronous, pulled-up row lines.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta_reg <= 4'b1111;
            row_sync_reg <= 4'b1111;
        end else begin
            row_meta_reg <= row_in;
            row_sync_reg <= row_meta_reg;
        end
    end

    assign sample_now = (div_cnt_reg == DIV_LAST);
    assign snap_done  = sample_now && (col_reg == 2'd3);
    // Column 3 rows are taken live on the completing cycle.
    assign snapshot   = {~row_sync_reg, snap_acc_reg};

    // Column timer and per-column row capture on the last cycle of each slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_reg  <= '0;
            col_reg      <= 2'd0;
            snap_acc_reg <= '0;
        end else if (sample_now) begin
            div_cnt_reg <= '0;
            col_reg     <= col_reg + 2'd1;
            case (col_reg)
                2'd0:    snap_acc_reg[3:0]  <= ~row_sync_reg;
                2'd1:    snap_acc_reg[7:4]  <= ~row_sync_reg;
                2'd2:    snap_acc_reg[11:8] <= ~row_sync_reg;
                default: ;
            endcase
        end else begin
            div_cnt_reg <= div_cnt_reg + 1'b1;
        end
    end

    // Classify the snapshot: how many keys are down and which one (if single).
    always_comb begin
        key_count = '0;
        key_idx   = '0;
        for (int i = 0; i < 16; i++) begin
            if (snapshot[i]) begin
                key_count = key_count + 5'd1;
                key_idx   = 4'(i);
            end
        end
    end

    assign snap_none   = (key_count == 5'd0);
    assign snap_single = (key_count == 5'd1);
    assign snap_code   = map_key(key_idx);

    // Decimal append; 28 bits covers 16_777_215*10 + 9 without wrapping.
    assign entry_x10  = 28'(entry_reg) * 28'd10 + 28'(snap_code);
    assign digit_fits = (digit_count_reg < 4'd8) && (entry_x10 <= 28'hFF_FFFF);

`ifdef KEYPAD_BACKSPACE_EN
    logic [23:0] entry_div10;
    assign entry_div10 = entry_reg / 24'd10;
`endif

    // Acceptance happens on the snapshot that brings the match count to DEBOUNCE_CNT.
    always_comb begin
        accept = 1'b0;
        if (snap_done && snap_single) begin
            case (state_reg)
                IDLE:    accept = (DEB == 4'd1);
                PRESS:   accept = (snap_code == cand_reg) && ((cnt_reg + 4'd1) == DEB);
                default: accept = 1'b0;
            endcase
        end
    end

    // Debounce FSM plus the entry/commit datapath driven by accepted keys.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            cand_reg        <= '0;
            cnt_reg         <= '0;
            rel_reg         <= '0;
            entry_reg       <= '0;
            digit_count_reg <= '0;
            value_reg       <= '0;
            value_valid_reg <= 1'b0;
            key_valid_reg   <= 1'b0;
            key_code_reg    <= '0;
            overflow_reg    <= 1'b0;
        end else begin
            value_valid_reg <= 1'b0;
            key_valid_reg   <= 1'b0;
            overflow_reg    <= 1'b0;

            if (snap_done) begin
                case (state_reg)
                    IDLE: begin
                        if (snap_single) begin
                            cand_reg  <= snap_code;
                            cnt_reg   <= 4'd1;
                            rel_reg   <= '0;
                            state_reg <= accept ? HELD : PRESS;
                        end
                    end
                    PRESS: begin
                        if (snap_single && (snap_code == cand_reg)) begin
                            cnt_reg <= cnt_reg + 4'd1;
                            if (accept) begin
                                state_reg <= HELD;
                                rel_reg   <= '0;
                            end
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                    HELD: begin
                        if (snap_none) begin
                            if ((rel_reg + 4'd1) == DEB) begin
                                state_reg <= IDLE;
                                rel_reg   <= '0;
                            end else begin
                                rel_reg <= rel_reg + 4'd1;
                            end
                        end else begin
                            rel_reg <= '0;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end

            if (accept) begin
                key_valid_reg <= 1'b1;
                key_code_reg  <= snap_code;
                if (snap_code <= 4'd9) begin
                    if (digit_fits) begin
                        entry_reg       <= entry_x10[23:0];
                        digit_count_reg <= digit_count_reg + 4'd1;
                    end else begin
                        overflow_reg <= 1'b1;
                    end
                end else begin
                    case (snap_code)
                        KEY_HASH: begin
                            value_reg       <= entry_reg;
                            value_valid_reg <= 1'b1;
                            entry_reg       <= '0;
                            digit_count_reg <= '0;
                        end
                        KEY_D: begin
                            entry_reg       <= '0;
                            digit_count_reg <= '0;
                        end
`ifdef KEYPAD_BACKSPACE_EN
                        KEY_STAR: begin
                            entry_reg <= entry_div10;
                            if (digit_count_reg != 4'd0)
                                digit_count_reg <= digit_count_reg - 4'd1;
                        end
`endif
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
